// File: rtl/tl45_fetch.sv
// rtl/tl45_fetch.sv - tl45 instruction-fetch stage (optional fetch timeout: TL45_FETCH_TIMEOUT_EN)
module tl45_fetch #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_pipe_stall,
  input  logic        i_pipe_flush,
  input  logic [31:0] i_flush_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic [31:0] o_buf_pc,
  output logic [31:0] o_buf_inst,
  output logic        o_fetch_err
);

  localparam logic [31:0] BUBBLE = 32'hF000_0000;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic [31:0] hold_q, hold_d;
  logic        mem_req;
  logic        xfer;

`ifdef TL45_FETCH_TIMEOUT_EN
  logic        gap_q, gap_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  // The timeout gap cycle forces the request low so the bus sees a fresh retry.
  assign mem_req     = i_reset_n & (state_q != S_HOLD) & ~gap_q;
  assign o_fetch_err = err_q;
`else
  // Request is combinational on reset so it drops immediately when reset asserts.
  assign mem_req     = i_reset_n & (state_q != S_HOLD);
  assign o_fetch_err = 1'b0;
`endif

  assign xfer       = mem_req & i_mem_ack;
  assign o_mem_req  = mem_req;
  assign o_mem_addr = addr_q;
  assign o_buf_pc   = buf_pc_q;
  assign o_buf_inst = buf_inst_q;

  // Next-state, pc, output-buffer and hold-buffer logic; flush overrides stall and ack.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    buf_pc_d   = buf_pc_q;
    buf_inst_d = buf_inst_q;
    hold_d     = hold_q;
`ifdef TL45_FETCH_TIMEOUT_EN
    gap_d      = 1'b0;
    err_d      = err_q;
    cnt_d      = cnt_q;
`endif

    if (i_pipe_flush) begin
      pc_d       = i_flush_pc;
      buf_pc_d   = 32'h0;
      buf_inst_d = BUBBLE;
      hold_d     = BUBBLE;
      if (state_q == S_DRAIN) begin
        // A drain that completes on this edge is done; otherwise keep draining.
        state_d = xfer ? S_FETCH : S_DRAIN;
      end else if (mem_req && !i_mem_ack) begin
        state_d = S_DRAIN;
      end else begin
        state_d = S_FETCH;
      end
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (xfer) begin
            if (i_pipe_stall) begin
              hold_d  = i_mem_data;
              state_d = S_HOLD;
            end else begin
              buf_inst_d = i_mem_data;
              buf_pc_d   = pc_q;
              pc_d       = pc_q + 32'd1;
            end
          end else if (!i_pipe_stall) begin
            buf_inst_d = BUBBLE;
            buf_pc_d   = pc_q;
          end
        end
        S_HOLD: begin
          if (!i_pipe_stall) begin
            buf_inst_d = hold_q;
            buf_pc_d   = pc_q;
            pc_d       = pc_q + 32'd1;
            state_d    = S_FETCH;
          end
        end
        S_DRAIN: begin
          if (xfer) begin
            state_d = S_FETCH;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end

`ifdef TL45_FETCH_TIMEOUT_EN
    if (i_pipe_flush) begin
      cnt_d = 32'h0;
      err_d = 1'b0;
    end else if (xfer) begin
      cnt_d = 32'h0;
    end else if (mem_req) begin
      if (cnt_q + 32'd1 >= TIMEOUT_CYCLES) begin
        // Give up on this request: one idle cycle, then fetch pc afresh.
        cnt_d   = 32'h0;
        gap_d   = 1'b1;
        err_d   = 1'b1;
        state_d = S_FETCH;
        if (!i_pipe_stall) begin
          buf_inst_d = BUBBLE;
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
`endif

    // While draining, the bus address must stay on the abandoned request.
    addr_d = (state_d == S_DRAIN) ? addr_q : pc_d;
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      addr_q     <= RESET_PC;
      buf_pc_q   <= 32'h0;
      buf_inst_q <= BUBBLE;
      hold_q     <= BUBBLE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      addr_q     <= addr_d;
      buf_pc_q   <= buf_pc_d;
      buf_inst_q <= buf_inst_d;
      hold_q     <= hold_d;
    end
  end

`ifdef TL45_FETCH_TIMEOUT_EN
  // Timeout counter, retry gap and sticky fault flag.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      gap_q <= 1'b0;
      err_q <= 1'b0;
      cnt_q <= 32'h0;
    end else begin
      gap_q <= gap_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_tl45_fetch.sv
// tb/tb_tl45_fetch.sv - scoreboard testbench for tl45_fetch
module tb_tl45_fetch;

  localparam logic [31:0] BUBBLE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] flush_pc = 32'h0;
  logic        ack = 1'b0;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic [31:0] mem_data;
  logic [31:0] o_buf_pc;
  logic [31:0] o_buf_inst;
  logic        o_fetch_err;

  int n_checks = 0;
  int n_pass   = 0;

  logic [63:0] exp_q[$];
  logic [63:0] obs_q[$];
  logic [63:0] last_w;
  logic [63:0] e_w, o_w;
  logic [31:0] exp_addr;

  // Memory model: each word holds its own address.
  assign mem_data = o_mem_addr;

  always #5 clk = ~clk;

  tl45_fetch #(.RESET_PC(32'h100), .TIMEOUT_CYCLES(4)) dut (
    .i_clk        (clk),
    .i_reset_n    (rst_n),
    .i_pipe_stall (stall),
    .i_pipe_flush (flush),
    .i_flush_pc   (flush_pc),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ack    (ack),
    .i_mem_data   (mem_data),
    .o_buf_pc     (o_buf_pc),
    .o_buf_inst   (o_buf_inst),
    .o_fetch_err  (o_fetch_err)
  );

  // Monitor: record each new non-bubble word delivered to decode.
  always @(negedge clk) begin
    if (!rst_n) begin
      last_w <= {32'h0, BUBBLE};
    end else begin
      if (o_buf_inst !== BUBBLE && {o_buf_pc, o_buf_inst} !== last_w)
        obs_q.push_back({o_buf_pc, o_buf_inst});
      last_w <= {o_buf_pc, o_buf_inst};
    end
  end

  task automatic drive(input logic s, input logic f, input logic [31:0] fpc, input logic a);
    stall = s; flush = f; flush_pc = fpc; ack = a;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (o_mem_req !== 1'b0) $display("FAIL reset_req got=%b exp=0", o_mem_req); else n_pass++;
    n_checks++; if (o_mem_addr !== 32'h100) $display("FAIL reset_addr got=%h exp=100", o_mem_addr); else n_pass++;
    n_checks++; if (o_buf_pc !== 32'h0) $display("FAIL reset_buf_pc got=%h exp=0", o_buf_pc); else n_pass++;
    n_checks++; if (o_buf_inst !== BUBBLE) $display("FAIL reset_buf_inst got=%h exp=%h", o_buf_inst, BUBBLE); else n_pass++;
    n_checks++; if (o_fetch_err !== 1'b0) $display("FAIL reset_err got=%b exp=0", o_fetch_err); else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++; if (o_mem_req !== 1'b1) $display("FAIL release_req got=%b exp=1", o_mem_req); else n_pass++;
    exp_addr = 32'h100;
  endtask

  task automatic test_stream();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      n_checks++; if (o_mem_addr !== exp_addr) $display("FAIL stream_addr got=%h exp=%h", o_mem_addr, exp_addr); else n_pass++;
      if (i == 1) begin
        n_checks++;
        if ({o_buf_pc, o_buf_inst} !== {32'h100, 32'h100})
          $display("FAIL stream_first got=%h/%h exp=100/100", o_buf_pc, o_buf_inst);
        else n_pass++;
      end
      drive(0, 0, 0, 1); exp_q.push_back({exp_addr, exp_addr}); exp_addr++;
    end
    @(negedge clk); drive(0, 0, 0, 0);
    repeat (2) @(negedge clk); #1;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL stream_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e_w = exp_q.pop_front();
      if (obs_q.size() > 0) o_w = obs_q.pop_front(); else o_w = '1;
      n_checks++; if (o_w !== e_w) $display("FAIL stream_word got=%h exp=%h", o_w, e_w); else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_stall();
    logic [31:0] a;
    a = exp_addr;
    @(negedge clk); drive(0, 0, 0, 1); exp_q.push_back({a, a});
    @(negedge clk);
    n_checks++; if (o_mem_addr !== a + 1) $display("FAIL stall_addr got=%h exp=%h", o_mem_addr, a + 1); else n_pass++;
    drive(1, 0, 0, 1); exp_q.push_back({a + 32'd1, a + 32'd1});
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (o_mem_req !== 1'b0) $display("FAIL stall_hold_req got=%b exp=0", o_mem_req); else n_pass++;
      n_checks++;
      if ({o_buf_pc, o_buf_inst} !== {a, a}) $display("FAIL stall_frozen got=%h/%h exp=%h/%h", o_buf_pc, o_buf_inst, a, a);
      else n_pass++;
      drive(1, 0, 0, 1);
    end
    @(negedge clk); drive(0, 0, 0, 0);
    @(negedge clk);
    n_checks++;
    if ({o_buf_pc, o_buf_inst} !== {a + 32'd1, a + 32'd1}) $display("FAIL stall_release got=%h/%h exp=%h", o_buf_pc, o_buf_inst, a + 1);
    else n_pass++;
    n_checks++;
    if ({o_mem_req, o_mem_addr} !== {1'b1, a + 32'd2}) $display("FAIL stall_next got=%b/%h exp=1/%h", o_mem_req, o_mem_addr, a + 2);
    else n_pass++;
    drive(0, 0, 0, 1); exp_q.push_back({a + 32'd2, a + 32'd2});
    @(negedge clk); drive(0, 0, 0, 1); exp_q.push_back({a + 32'd3, a + 32'd3});
    @(negedge clk); drive(0, 0, 0, 0);
    repeat (2) @(negedge clk); #1;
    exp_addr = a + 32'd4;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL stall_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e_w = exp_q.pop_front();
      if (obs_q.size() > 0) o_w = obs_q.pop_front(); else o_w = '1;
      n_checks++; if (o_w !== e_w) $display("FAIL stall_word got=%h exp=%h", o_w, e_w); else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_flush();
    logic [31:0] b;
    b = exp_addr;
    @(negedge clk); drive(0, 1, 32'h40, 0);
    @(negedge clk);
    n_checks++; if ({o_mem_req, o_mem_addr} !== {1'b1, b}) $display("FAIL flush_drain_addr got=%b/%h exp=1/%h", o_mem_req, o_mem_addr, b); else n_pass++;
    n_checks++;
    if ({o_buf_pc, o_buf_inst} !== {32'h0, BUBBLE}) $display("FAIL flush_bubble got=%h/%h exp=0/%h", o_buf_pc, o_buf_inst, BUBBLE);
    else n_pass++;
    drive(0, 0, 0, 0);
    @(negedge clk); drive(0, 0, 0, 1);
    @(negedge clk);
    n_checks++; if (o_buf_inst !== BUBBLE) $display("FAIL flush_discard got=%h exp=%h", o_buf_inst, BUBBLE); else n_pass++;
    n_checks++; if (o_mem_addr !== 32'h40) $display("FAIL flush_target got=%h exp=40", o_mem_addr); else n_pass++;
    drive(0, 0, 0, 1); exp_q.push_back({32'h40, 32'h40});
    @(negedge clk); drive(0, 0, 0, 1); exp_q.push_back({32'h41, 32'h41});
    @(negedge clk); drive(0, 0, 0, 0);
    repeat (2) @(negedge clk); #1;
    exp_addr = 32'h42;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL flush_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e_w = exp_q.pop_front();
      if (obs_q.size() > 0) o_w = obs_q.pop_front(); else o_w = '1;
      n_checks++; if (o_w !== e_w) $display("FAIL flush_word got=%h exp=%h", o_w, e_w); else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_flush_ack();
    @(negedge clk); drive(0, 1, 32'h200, 1);
    @(negedge clk);
    n_checks++;
    if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h200}) $display("FAIL flush_ack_addr got=%b/%h exp=1/200", o_mem_req, o_mem_addr);
    else n_pass++;
    n_checks++; if (o_buf_inst !== BUBBLE) $display("FAIL flush_ack_bubble got=%h exp=%h", o_buf_inst, BUBBLE); else n_pass++;
    drive(0, 0, 0, 1); exp_q.push_back({32'h200, 32'h200});
    @(negedge clk); drive(0, 0, 0, 0);
    repeat (2) @(negedge clk); #1;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL flush_ack_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e_w = exp_q.pop_front();
      if (obs_q.size() > 0) o_w = obs_q.pop_front(); else o_w = '1;
      n_checks++; if (o_w !== e_w) $display("FAIL flush_ack_word got=%h exp=%h", o_w, e_w); else n_pass++;
    end
    obs_q.delete();
  endtask

  task automatic test_wrap_and_reset();
    @(negedge clk); drive(0, 1, 32'hFFFF_FFFF, 1);
    @(negedge clk);
    n_checks++; if (o_mem_addr !== 32'hFFFF_FFFF) $display("FAIL wrap_start got=%h exp=ffffffff", o_mem_addr); else n_pass++;
    drive(0, 0, 0, 1); exp_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFF});
    @(negedge clk);
    n_checks++; if (o_mem_addr !== 32'h0) $display("FAIL wrap_addr got=%h exp=0", o_mem_addr); else n_pass++;
    drive(0, 0, 0, 1); exp_q.push_back({32'h0, 32'h0});
    @(negedge clk); drive(0, 0, 0, 0);
    repeat (2) @(negedge clk); #1;
    n_checks++; if (obs_q.size() != exp_q.size()) $display("FAIL wrap_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); else n_pass++;
    while (exp_q.size() > 0) begin
      e_w = exp_q.pop_front();
      if (obs_q.size() > 0) o_w = obs_q.pop_front(); else o_w = '1;
      n_checks++; if (o_w !== e_w) $display("FAIL wrap_word got=%h exp=%h", o_w, e_w); else n_pass++;
    end
    obs_q.delete();
    // Reset mid-request, away from any clock edge.
    @(negedge clk); #2;
    ack = 1'b1;
    rst_n = 1'b0;
    #1;
    n_checks++; if (o_mem_req !== 1'b0) $display("FAIL async_reset_req got=%b exp=0", o_mem_req); else n_pass++;
    n_checks++;
    if ({o_mem_addr, o_buf_pc, o_buf_inst} !== {32'h100, 32'h0, BUBBLE})
      $display("FAIL async_reset_state got=%h/%h/%h exp=100/0/%h", o_mem_addr, o_buf_pc, o_buf_inst, BUBBLE);
    else n_pass++;
    @(negedge clk); drive(0, 0, 0, 0); rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({o_mem_req, o_mem_addr, o_buf_inst} !== {1'b1, 32'h100, BUBBLE})
      $display("FAIL reset_restart got=%b/%h/%h exp=1/100/%h", o_mem_req, o_mem_addr, o_buf_inst, BUBBLE);
    else n_pass++;
    obs_q.delete();
  endtask

`ifdef TL45_FETCH_TIMEOUT_EN
  task automatic test_timeout();
    @(negedge clk); drive(0, 1, 32'h300, 1);
    @(negedge clk); drive(0, 0, 0, 0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      n_checks++;
      if ({o_mem_req, o_fetch_err} !== 2'b10) $display("FAIL timeout_wait got=%b/%b exp=1/0", o_mem_req, o_fetch_err);
      else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({o_mem_req, o_fetch_err, o_buf_inst} !== {1'b0, 1'b1, BUBBLE})
      $display("FAIL timeout_fault got=%b/%b/%h exp=0/1/%h", o_mem_req, o_fetch_err, o_buf_inst, BUBBLE);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({o_mem_req, o_fetch_err, o_mem_addr} !== {1'b1, 1'b1, 32'h300})
      $display("FAIL timeout_retry got=%b/%b/%h exp=1/1/300", o_mem_req, o_fetch_err, o_mem_addr);
    else n_pass++;
    drive(0, 1, 32'h300, 1);
    @(negedge clk);
    n_checks++; if (o_fetch_err !== 1'b0) $display("FAIL timeout_clear got=%b exp=0", o_fetch_err); else n_pass++;
    drive(0, 0, 0, 0);
    obs_q.delete();
  endtask
`else
  task automatic test_no_timeout();
    @(negedge clk); drive(0, 0, 0, 0);
    repeat (20) @(negedge clk);
    n_checks++;
    if ({o_mem_req, o_mem_addr, o_fetch_err, o_buf_inst} !== {1'b1, 32'h100, 1'b0, BUBBLE})
      $display("FAIL wait_forever got=%b/%h/%b/%h exp=1/100/0/%h", o_mem_req, o_mem_addr, o_fetch_err, o_buf_inst, BUBBLE);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_flush();
    test_flush_ack();
    test_wrap_and_reset();
`ifdef TL45_FETCH_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
